// File: rtl/side_buf_reinject.sv
// rtl/side_buf_reinject.sv - side-buffer FIFO with reinjection and starvation redirect
//
// Purpose:
//   Holds flits deflected by the eject stage in a small FIFO. The head flit
//   goes back into the lowest-index empty router channel. If the buffer sits
//   non-empty without a chance to reinject for REDIRECT_THRESH cycles, it
//   raises a one-cycle redirect. In that cycle the head takes the place of
//   the channel selected by rand_num, and the displaced (victim) flit is
//   stored in the buffer.
//
// Ports:
//   clk               single clock, rising edge
//   reset             synchronous, active-high
//   rand_num [1:0]    victim channel index for a forced redirect
//   side_buf_din      flit deflected into the side buffer
//   side_buf_din_vld  side_buf_din valid this cycle
//   din_0..din_3      channel flits after ejection (.valid = occupied)
//   dout_0..dout_3    channel flits after reinjection / redirect
//   full              buffer holds SIDE_BUF_DEPTH flits
//   redirect_gnt      forced redirect this cycle; eject stage must not push

package side_buf_reinject_pkg;
  typedef struct packed {
    logic        valid;
    logic        deflect;
    logic [3:0]  dest;
    logic [15:0] data;
  } flit_int_t;
endpackage

module side_buf_reinject
  import side_buf_reinject_pkg::*;
#(
  parameter int SIDE_BUF_DEPTH  = 4,
  parameter int REDIRECT_THRESH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rand_num,
  input  flit_int_t  side_buf_din,
  input  logic       side_buf_din_vld,
  input  flit_int_t  din_0,
  input  flit_int_t  din_1,
  input  flit_int_t  din_2,
  input  flit_int_t  din_3,
  output flit_int_t  dout_0,
  output flit_int_t  dout_1,
  output flit_int_t  dout_2,
  output flit_int_t  dout_3,
  output logic       full,
  output logic       redirect_gnt
);

  localparam int PW = $clog2(SIDE_BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(REDIRECT_THRESH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(SIDE_BUF_DEPTH);
  localparam logic [SW-1:0] THRESH_C = SW'(REDIRECT_THRESH);

  // Storage and control state
  flit_int_t     mem_q [SIDE_BUF_DEPTH];
  flit_int_t     mem_d [SIDE_BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          redirect_gnt_q, redirect_gnt_d;

  // Channel views as arrays
  flit_int_t din_a  [4];
  flit_int_t dout_a [4];

  flit_int_t head;
  flit_int_t head_out;
  flit_int_t wdata;
  logic      empty;
  logic      full_int;
  logic      any_empty;
  logic [1:0] first_idx;
  logic      pop;
  logic      victim;
  logic      push_ext;
  logic      push;

  assign din_a[0] = din_0;
  assign din_a[1] = din_1;
  assign din_a[2] = din_2;
  assign din_a[3] = din_3;

  assign dout_0 = dout_a[0];
  assign dout_1 = dout_a[1];
  assign dout_2 = dout_a[2];
  assign dout_3 = dout_a[3];

  assign full_int = (count_q == DEPTH_C);
  // The flops may still hold stale values during the first reset cycle, so
  // the visible flags are masked by reset.
  assign full         = full_int & ~reset;
  assign redirect_gnt = redirect_gnt_q & ~reset;

  always_comb begin
    empty = (count_q == '0);

    head             = mem_q[rd_ptr_q];
    head_out         = head;
    head_out.valid   = 1'b1;
    head_out.deflect = 1'b0;

    // Scan from high to low so the lowest empty channel wins.
    any_empty = 1'b0;
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!din_a[i].valid) begin
        any_empty = 1'b1;
        first_idx = 2'(i);
      end
    end

    // Reinjection always takes a free slot first. Only when every channel is
    // occupied does a pending redirect displace a victim.
    dout_a = din_a;
    pop    = 1'b0;
    victim = 1'b0;
    if (!reset && !empty) begin
      if (any_empty) begin
        pop               = 1'b1;
        dout_a[first_idx] = head_out;
      end else if (redirect_gnt_q) begin
        pop              = 1'b1;
        victim           = 1'b1;
        dout_a[rand_num] = head_out;
      end
    end

    // External pushes are refused while full or while a redirect owns the
    // write port. A victim push and an external push never coincide.
    push_ext = !reset && side_buf_din_vld && !full_int && !redirect_gnt_q;
    push     = push_ext || victim;

    wdata         = victim ? din_a[rand_num] : side_buf_din;
    wdata.deflect = 1'b0;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
    end

    // The pointers wrap naturally because the depth is a power of two.
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // The starve count covers cycles in which the head wanted out but got no
    // slot. A redirect cycle always pops, so it also clears the counter.
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != THRESH_C) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    redirect_gnt_d = (starve_d == THRESH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      starve_q       <= '0;
      redirect_gnt_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      starve_q       <= starve_d;
      redirect_gnt_q <= redirect_gnt_d;
    end
  end

endmodule

// File: tb/tb_side_buf_reinject.sv
// tb/tb_side_buf_reinject.sv - self-checking bench for side_buf_reinject
module tb_side_buf_reinject;
  import side_buf_reinject_pkg::*;

  localparam int DEPTH  = 4;
  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rand_num;
  flit_int_t  side_buf_din;
  logic       side_buf_din_vld;
  flit_int_t  din_0, din_1, din_2, din_3;
  flit_int_t  dout_0, dout_1, dout_2, dout_3;
  logic       full;
  logic       redirect_gnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  side_buf_reinject #(.SIDE_BUF_DEPTH(DEPTH), .REDIRECT_THRESH(THRESH)) dut (
    .clk              (clk),
    .reset            (reset),
    .rand_num         (rand_num),
    .side_buf_din     (side_buf_din),
    .side_buf_din_vld (side_buf_din_vld),
    .din_0            (din_0),
    .din_1            (din_1),
    .din_2            (din_2),
    .din_3            (din_3),
    .dout_0           (dout_0),
    .dout_1           (dout_1),
    .dout_2           (dout_2),
    .dout_3           (dout_3),
    .full             (full),
    .redirect_gnt     (redirect_gnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_int_t mk(input bit v, input bit d, input logic [3:0] dest,
                                   input logic [15:0] data);
    flit_int_t f;
    f.valid   = v;
    f.deflect = d;
    f.dest    = dest;
    f.data    = data;
    return f;
  endfunction

  // Channel i carries dest=i, data=base+i, deflect set so that any flit
  // coming back out of the buffer visibly has it cleared.
  task automatic set_din(input bit [3:0] vmask, input logic [15:0] base);
    din_0 = mk(vmask[0], 1'b1, 4'd0, base);
    din_1 = mk(vmask[1], 1'b1, 4'd1, base + 16'd1);
    din_2 = mk(vmask[2], 1'b1, 4'd2, base + 16'd2);
    din_3 = mk(vmask[3], 1'b1, 4'd3, base + 16'd3);
  endtask

  function automatic flit_int_t rnd_flit(input int vprob);
    flit_int_t f;
    f.valid   = ($urandom_range(0, 99) < vprob);
    f.deflect = 1'($urandom);
    f.dest    = 4'($urandom);
    f.data    = 16'($urandom);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the buffer is a queue, the starvation rule is applied
  // directly, and the expected outputs follow from the reinject/redirect rules.
  flit_int_t mq[$];
  int        m_starve = 0;
  bit        m_gnt    = 1'b0;

  always @(negedge clk) begin
    flit_int_t din_a [4];
    flit_int_t exp_a [4];
    flit_int_t act_a [4];
    flit_int_t h;
    flit_int_t f;
    int        sz;
    int        first;
    bit        efull;
    bit        popd;
    bit        vict;

    din_a = '{din_0, din_1, din_2, din_3};
    act_a = '{dout_0, dout_1, dout_2, dout_3};
    exp_a = din_a;

    if (reset) begin
      chk("model_full", 64'(full), 64'(0));
      chk("model_gnt", 64'(redirect_gnt), 64'(0));
      for (int i = 0; i < 4; i++) chk($sformatf("model_dout%0d", i), 64'(act_a[i]), 64'(exp_a[i]));
      mq.delete();
      m_starve = 0;
      m_gnt    = 1'b0;
    end else begin
      sz    = mq.size();
      efull = (sz == DEPTH);
      first = -1;
      for (int i = 0; i < 4; i++) if (!din_a[i].valid && first < 0) first = i;
      popd = 1'b0;
      vict = 1'b0;
      if (sz > 0) begin
        h = mq[0];
        h.valid   = 1'b1;
        h.deflect = 1'b0;
        if (first >= 0) begin
          exp_a[first] = h;
          popd = 1'b1;
        end else if (m_gnt) begin
          exp_a[rand_num] = h;
          popd = 1'b1;
          vict = 1'b1;
        end
      end
      chk("model_full", 64'(full), 64'(efull));
      chk("model_gnt", 64'(redirect_gnt), 64'(m_gnt));
      for (int i = 0; i < 4; i++) chk($sformatf("model_dout%0d", i), 64'(act_a[i]), 64'(exp_a[i]));

      // Advance to the state after the coming rising edge.
      if (popd) void'(mq.pop_front());
      if (vict) begin
        f = din_a[rand_num];
        f.deflect = 1'b0;
        mq.push_back(f);
      end else if (side_buf_din_vld && !efull && !m_gnt) begin
        f = side_buf_din;
        f.deflect = 1'b0;
        mq.push_back(f);
      end
      if (sz == 0 || popd) m_starve = 0;
      else if (m_starve < THRESH) m_starve++;
      m_gnt = (m_starve == THRESH);
    end
  end

  initial begin
    int vprob;

    reset            = 1'b1;
    rand_num         = 2'd0;
    side_buf_din     = '0;
    side_buf_din_vld = 1'b0;
    set_din(4'b1111, 16'h0100);
    tick();
    tick();
    reset = 1'b0;

    // Single flit into the only free channel
    side_buf_din     = mk(1'b1, 1'b1, 4'd5, 16'hA5A5);
    side_buf_din_vld = 1'b1;
    set_din(4'b1111, 16'h0200);
    @(negedge clk);
    chk("r029_no_bypass", 64'(dout_2), 64'(mk(1'b1, 1'b1, 4'd2, 16'h0202)));
    tick();
    side_buf_din_vld = 1'b0;
    set_din(4'b1011, 16'h0210);
    @(negedge clk);
    chk("r029_dout2", 64'(dout_2), 64'(mk(1'b1, 1'b0, 4'd5, 16'hA5A5)));
    chk("r029_dout0_pass", 64'(dout_0), 64'(mk(1'b1, 1'b1, 4'd0, 16'h0210)));
    tick();
    set_din(4'b0000, 16'h0220);
    @(negedge clk);
    chk("r029_drained", 64'(dout_0.valid), 64'(0));
    tick();

    // Fill to full, drop the fifth push, then drain in order
    set_din(4'b1111, 16'h0300);
    for (int k = 0; k < 5; k++) begin
      side_buf_din     = mk(1'b1, 1'b0, 4'(k), 16'h3000 + 16'(k));
      side_buf_din_vld = 1'b1;
      @(negedge clk);
      chk($sformatf("r030_full_k%0d", k), 64'(full), 64'(k >= 4));
      tick();
    end
    side_buf_din_vld = 1'b0;
    @(negedge clk);
    chk("r030_still_full", 64'(full), 64'(1));
    tick();
    for (int j = 0; j < 4; j++) begin
      set_din(4'b1110, 16'h0310);
      @(negedge clk);
      chk($sformatf("r030_drain%0d", j), 64'(dout_0), 64'(mk(1'b1, 1'b0, 4'(j), 16'h3000 + 16'(j))));
      tick();
    end
    set_din(4'b0000, 16'h0320);
    @(negedge clk);
    chk("r030_empty", 64'(dout_0.valid), 64'(0));
    chk("r030_not_full", 64'(full), 64'(0));
    tick();

    // Forced redirect with all channels occupied
    side_buf_din     = mk(1'b1, 1'b1, 4'd7, 16'h3131);
    side_buf_din_vld = 1'b1;
    set_din(4'b1111, 16'h0400);
    tick();
    side_buf_din_vld = 1'b0;
    rand_num         = 2'd3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("r031_gnt_low_c%0d", c), 64'(redirect_gnt), 64'(0));
      tick();
    end
    din_3 = mk(1'b1, 1'b1, 4'd9, 16'h7777);
    @(negedge clk);
    chk("r031_gnt_c9", 64'(redirect_gnt), 64'(1));
    chk("r031_dout3_head", 64'(dout_3), 64'(mk(1'b1, 1'b0, 4'd7, 16'h3131)));
    chk("r031_dout0_pass", 64'(dout_0), 64'(mk(1'b1, 1'b1, 4'd0, 16'h0400)));
    tick();
    set_din(4'b1110, 16'h0410);
    @(negedge clk);
    chk("r031_gnt_c10", 64'(redirect_gnt), 64'(0));
    chk("r031_victim_out", 64'(dout_0), 64'(mk(1'b1, 1'b0, 4'd9, 16'h7777)));
    tick();
    set_din(4'b0000, 16'h0420);
    @(negedge clk);
    chk("r031_empty", 64'(dout_0.valid), 64'(0));
    tick();

    // Redirect cycle that finds a free channel
    side_buf_din     = mk(1'b1, 1'b1, 4'd4, 16'h3434);
    side_buf_din_vld = 1'b1;
    set_din(4'b1111, 16'h0500);
    tick();
    side_buf_din_vld = 1'b0;
    rand_num         = 2'd2;
    for (int c = 1; c <= 8; c++) tick();
    set_din(4'b1101, 16'h0510);
    @(negedge clk);
    chk("r034_gnt", 64'(redirect_gnt), 64'(1));
    chk("r034_dout1_head", 64'(dout_1), 64'(mk(1'b1, 1'b0, 4'd4, 16'h3434)));
    chk("r034_dout2_kept", 64'(dout_2), 64'(mk(1'b1, 1'b1, 4'd2, 16'h0512)));
    tick();
    set_din(4'b0000, 16'h0520);
    @(negedge clk);
    chk("r034_no_victim", 64'(dout_0.valid), 64'(0));
    chk("r034_gnt_low", 64'(redirect_gnt), 64'(0));
    tick();

    // Push and pop together at count 2, six flits through the wrap
    set_din(4'b1111, 16'h0600);
    for (int k = 0; k < 2; k++) begin
      side_buf_din     = mk(1'b1, 1'b1, 4'(k), 16'h3200 + 16'(k));
      side_buf_din_vld = 1'b1;
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      side_buf_din     = mk(1'b1, 1'b1, 4'(j + 2), 16'h3200 + 16'(j + 2));
      side_buf_din_vld = (j < 4);
      set_din(4'b0111, 16'h0610);
      @(negedge clk);
      chk($sformatf("r032_order%0d", j), 64'(dout_3), 64'(mk(1'b1, 1'b0, 4'(j), 16'h3200 + 16'(j))));
      tick();
    end
    side_buf_din_vld = 1'b0;
    set_din(4'b0000, 16'h0620);
    @(negedge clk);
    chk("r032_empty", 64'(dout_3.valid), 64'(0));
    tick();

    // Reset in the middle of operation with count=3, starve=5
    set_din(4'b1111, 16'h0700);
    for (int k = 0; k < 3; k++) begin
      side_buf_din     = mk(1'b1, 1'b0, 4'(k), 16'h3300 + 16'(k));
      side_buf_din_vld = 1'b1;
      tick();
    end
    side_buf_din_vld = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    set_din(4'b1010, 16'h0710);
    @(negedge clk);
    chk("r033_rst_dout0", 64'(dout_0), 64'(mk(1'b0, 1'b1, 4'd0, 16'h0710)));
    chk("r033_rst_dout3", 64'(dout_3), 64'(mk(1'b1, 1'b1, 4'd3, 16'h0713)));
    chk("r033_rst_full", 64'(full), 64'(0));
    chk("r033_rst_gnt", 64'(redirect_gnt), 64'(0));
    tick();
    reset = 1'b0;
    set_din(4'b0000, 16'h0720);
    @(negedge clk);
    chk("r033_after_empty", 64'(dout_0.valid), 64'(0));
    chk("r033_after_full", 64'(full), 64'(0));
    chk("r033_after_gnt", 64'(redirect_gnt), 64'(0));
    tick();

    // Randomized traffic checked by the model
    vprob = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0:       vprob = 50;
          1:       vprob = 85;
          default: vprob = 100;
        endcase
      end
      reset            = ($urandom_range(0, 299) == 0);
      rand_num         = 2'($urandom);
      side_buf_din_vld = ($urandom_range(0, 99) < 40);
      side_buf_din     = rnd_flit(100);
      din_0            = rnd_flit(vprob);
      din_1            = rnd_flit(vprob);
      din_2            = rnd_flit(vprob);
      din_3            = rnd_flit(vprob);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
